// File: rtl/singleport_sync_if.sv
// Request/response bundle for singleport_sync: one access per cycle, registered read data.
// The master drives re/we/addr/data_in/be; the memory returns data_out/rd_valid/busy/err.
interface singleport_sync_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   logic                    re;
   logic                    we;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   data_in;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   data_out;
   logic                    rd_valid;
   logic                    busy;
   logic                    err;

   modport master (
      output re, we, addr, data_in, be,
      input  data_out, rd_valid, busy, err
   );

   modport slave (
      input  re, we, addr, data_in, be,
      output data_out, rd_valid, busy, err
   );
endinterface

// File: rtl/singleport_sync.sv
// Synchronous single-port RAM with byte enables, post-reset zero fill and conflict flag; 1-cycle read.
// No stall path: requests while busy, or with re and we together, are dropped and flagged on err.
module singleport_sync #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 3,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   singleport_sync_if.slave bus
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  rd_valid_q;
   logic                  err_q;
   logic                  busy_q;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NB-1:0]         wr_be;
   logic                  rd_go;
   logic                  reject;

   always_comb begin
      state_d = state_q;
      mem_we  = 1'b0;
      wr_addr = bus.addr;
      wr_data = bus.data_in;
      wr_be   = bus.be;
      rd_go   = 1'b0;
      reject  = 1'b0;
      if (!rst) begin
         case (state_q)
            CLEAR: begin
               mem_we  = 1'b1;
               wr_addr = clr_cnt;
               wr_data = '0;
               wr_be   = '1;
               reject  = bus.re | bus.we;
               if (clr_cnt == '1)
                  state_d = READY;
            end
            READY: begin
               // busy_q is still high for the first edge after reset when no clear runs
               if (busy_q) begin
                  reject = bus.re | bus.we;
               end else begin
                  mem_we = bus.we & ~bus.re;
                  rd_go  = bus.re & ~bus.we;
                  reject = bus.re & bus.we;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR_ON_RESET ? CLEAR : READY;
         clr_cnt    <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         if (state_q == CLEAR)
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
         rd_valid_q <= rd_go;
         err_q      <= reject;
         busy_q     <= (state_d == CLEAR);
         if (rd_go)
            data_out_q <= mem[bus.addr];
      end
   end

   // Storage has no reset: contents survive rst and are only zeroed by the clear walk.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_be[k])
               mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.err      = err_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_singleport_sync.sv
// Bench for singleport_sync: default instance checked every cycle against a behavioural model,
// plus a 32-bit/32-word instance without clear exercised by directed vectors.
module tb_singleport_sync;
   logic clk;
   logic rst1;
   logic rst2;
   int   checks;
   int   errors;

   singleport_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus1 ();
   singleport_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus2 ();

   singleport_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .CLEAR_ON_RESET(1'b1)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (bus1)
   );

   singleport_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CLEAR_ON_RESET(1'b0)) dut2 (
      .clk (clk),
      .rst (rst2),
      .bus (bus2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model of the default instance: busy lasts 8 non-reset edges, memory is all zero afterwards.
   logic [15:0] m_mem [8];
   int          m_left;
   bit          m_on;
   logic [15:0] e_dout;
   logic        e_vld;
   logic        e_err;
   logic        e_busy;

   initial begin
      m_on   = 1'b0;
      m_left = 0;
   end

   always @(posedge clk) begin
      if (rst1) begin
         m_on   = 1'b1;
         m_left = 8;
         e_dout = '0;
         e_vld  = 1'b0;
         e_err  = 1'b0;
         e_busy = 1'b1;
      end else if (m_left > 0) begin
         e_vld  = 1'b0;
         e_err  = bus1.re | bus1.we;
         m_left = m_left - 1;
         e_busy = (m_left != 0);
         if (m_left == 0)
            for (int i = 0; i < 8; i++) m_mem[i] = '0;
      end else begin
         e_busy = 1'b0;
         e_err  = bus1.re & bus1.we;
         e_vld  = bus1.re & ~bus1.we;
         if (e_vld)
            e_dout = m_mem[bus1.addr];
         if (bus1.we && !bus1.re)
            for (int k = 0; k < 2; k++)
               if (bus1.be[k]) m_mem[bus1.addr][8*k +: 8] = bus1.data_in[8*k +: 8];
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("model_busy", {31'd0, bus1.busy}, {31'd0, e_busy});
         chk("model_err", {31'd0, bus1.err}, {31'd0, e_err});
         chk("model_rd_valid", {31'd0, bus1.rd_valid}, {31'd0, e_vld});
         chk("model_data_out", {16'd0, bus1.data_out}, {16'd0, e_dout});
      end
   end

   // Drive a request at the negedge, let one posedge sample it, return at the next negedge.
   task automatic req(input logic r, input logic w, input logic [2:0] a,
                      input logic [15:0] d, input logic [1:0] b);
      bus1.re = r; bus1.we = w; bus1.addr = a; bus1.data_in = d; bus1.be = b;
      @(negedge clk);
   endtask

   task automatic req2(input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] b);
      bus2.re = r; bus2.we = w; bus2.addr = a; bus2.data_in = d; bus2.be = b;
      @(negedge clk);
   endtask

   task automatic idle();
      req(1'b0, 1'b0, 3'd0, 16'd0, 2'b00);
   endtask

   task automatic count_busy(input string nm);
      int n;
      n = 0;
      while (bus1.busy && n < 40) begin
         idle();
         n++;
      end
      chk(nm, n, 8);
   endtask

   logic [15:0] vals [8];

   initial begin
      checks = 0;
      errors = 0;
      rst1 = 1'b1;
      rst2 = 1'b1;
      bus2.re = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.data_in = '0; bus2.be = '0;

      // reset then clear
      idle();
      idle();
      chk("rst_busy", {31'd0, bus1.busy}, 32'd1);
      chk("rst_rd_valid", {31'd0, bus1.rd_valid}, 32'd0);
      chk("rst_data_out", {16'd0, bus1.data_out}, 32'd0);
      chk("rst_err", {31'd0, bus1.err}, 32'd0);
      rst1 = 1'b0;
      count_busy("clear_busy_edges");
      for (int a = 0; a < 8; a++) begin
         req(1'b1, 1'b0, 3'(a), 16'd0, 2'b00);
         chk("clear_read_zero", {16'd0, bus1.data_out}, 32'd0);
         chk("clear_read_vld", {31'd0, bus1.rd_valid}, 32'd1);
      end

      // full write then back-to-back readback
      for (int a = 0; a < 8; a++) begin
         vals[a] = 16'($urandom);
         req(1'b0, 1'b1, 3'(a), vals[a], 2'b11);
      end
      for (int a = 0; a < 8; a++) begin
         req(1'b1, 1'b0, 3'(a), 16'd0, 2'b00);
         chk("readback_data", {16'd0, bus1.data_out}, {16'd0, vals[a]});
         chk("readback_vld", {31'd0, bus1.rd_valid}, 32'd1);
      end
      idle();
      chk("readback_vld_drop", {31'd0, bus1.rd_valid}, 32'd0);

      // byte enables
      req(1'b0, 1'b1, 3'd5, 16'hA5C3, 2'b11);
      req(1'b0, 1'b1, 3'd5, 16'hFF00, 2'b01);
      req(1'b1, 1'b0, 3'd5, 16'h0000, 2'b00);
      chk("be_low_only", {16'd0, bus1.data_out}, 32'h0000_A500);
      chk("model_pin_a500", {16'd0, e_dout}, 32'h0000_A500);
      req(1'b0, 1'b1, 3'd5, 16'h1234, 2'b00);
      req(1'b1, 1'b0, 3'd5, 16'h0000, 2'b00);
      chk("be_none_noop", {16'd0, bus1.data_out}, 32'h0000_A500);

      // read-after-write plus conflict
      req(1'b0, 1'b1, 3'd2, 16'h1234, 2'b11);
      req(1'b1, 1'b1, 3'd2, 16'h5555, 2'b11);
      chk("conflict_err", {31'd0, bus1.err}, 32'd1);
      chk("conflict_no_vld", {31'd0, bus1.rd_valid}, 32'd0);
      chk("conflict_dout_holds", {16'd0, bus1.data_out}, 32'h0000_A500);
      idle();
      chk("conflict_err_one_cycle", {31'd0, bus1.err}, 32'd0);
      req(1'b1, 1'b0, 3'd2, 16'h0000, 2'b00);
      chk("conflict_mem_kept", {16'd0, bus1.data_out}, 32'h0000_1234);

      // requests during clear are rejected, including on the final clear edge
      rst1 = 1'b1;
      idle();
      rst1 = 1'b0;
      req(1'b0, 1'b1, 3'd3, 16'hFFFF, 2'b11);
      chk("clear_req_err", {31'd0, bus1.err}, 32'd1);
      chk("clear_req_busy", {31'd0, bus1.busy}, 32'd1);
      for (int i = 0; i < 6; i++) idle();
      req(1'b0, 1'b1, 3'd0, 16'hFFFF, 2'b11);
      chk("clear_last_err", {31'd0, bus1.err}, 32'd1);
      chk("clear_last_busy_low", {31'd0, bus1.busy}, 32'd0);
      req(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00);
      chk("clear_req_no_write", {16'd0, bus1.data_out}, 32'd0);

      // reset at clear step 4 restarts the full clear
      req(1'b0, 1'b1, 3'd7, 16'hBEEF, 2'b11);
      rst1 = 1'b1;
      idle();
      rst1 = 1'b0;
      for (int i = 0; i < 3; i++) idle();
      rst1 = 1'b1;
      idle();
      chk("midclear_busy", {31'd0, bus1.busy}, 32'd1);
      rst1 = 1'b0;
      count_busy("midclear_busy_edges");
      req(1'b1, 1'b0, 3'd7, 16'h0000, 2'b00);
      chk("midclear_zeroed", {16'd0, bus1.data_out}, 32'd0);

      // reset right after a read
      req(1'b0, 1'b1, 3'd4, 16'h4444, 2'b11);
      req(1'b1, 1'b0, 3'd4, 16'h0000, 2'b00);
      chk("raw_read", {16'd0, bus1.data_out}, 32'h0000_4444);
      rst1 = 1'b1;
      idle();
      chk("rst_after_read_vld", {31'd0, bus1.rd_valid}, 32'd0);
      chk("rst_after_read_dout", {16'd0, bus1.data_out}, 32'd0);
      rst1 = 1'b0;
      count_busy("final_busy_edges");

      // wide instance without clear
      req2(1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
      chk("w_rst_busy", {31'd0, bus2.busy}, 32'd1);
      rst2 = 1'b0;
      req2(1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
      chk("w_busy_one_edge", {31'd0, bus2.busy}, 32'd0);
      req2(1'b0, 1'b1, 5'd31, 32'hDEADBEEF, 4'hF);
      req2(1'b1, 1'b0, 5'd31, 32'd0, 4'h0);
      chk("w_read31", bus2.data_out, 32'hDEADBEEF);
      chk("w_read31_vld", {31'd0, bus2.rd_valid}, 32'd1);
      req2(1'b0, 1'b1, 5'd31, 32'h00110000, 4'b0100);
      req2(1'b1, 1'b0, 5'd31, 32'd0, 4'h0);
      chk("w_byte2", bus2.data_out, 32'hDE11BEEF);
      req2(1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
      chk("w_vld_drop", {31'd0, bus2.rd_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
